// File: rtl/can_bit_sampler.sv
// CAN RX bit sampler: synchronizer, tq/bit timing with hard sync at SOF, sample-point
// capture, destuffing, stuff-error and bus-idle detection. Define RESYNC_EN for soft resync.
module can_bit_sampler #(
  parameter int CLK_PER_TQ = 4,
  parameter int TQ_PER_BIT = 10,
  parameter int SAMPLE_TQ  = 7,
  parameter int SJW        = 2,
  parameter int IDLE_BITS  = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic can_rx,
  input  logic destuff_stop,
  output logic can_data,
  output logic sample,
  output logic sof,
  output logic stuff_err,
  output logic bus_idle,
  output logic frame_active
);

  localparam int PW  = (CLK_PER_TQ > 1) ? $clog2(CLK_PER_TQ) : 1;
  localparam int TQW = $clog2(TQ_PER_BIT + SJW + 1);
  localparam int IW  = $clog2(IDLE_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           rx_meta_q, rx_s_q, rx_prev_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic [TQW-1:0] tq_q, tq_d;
  logic [2:0]     run_q, run_d;
  logic           last_q, last_d;
  logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
  logic           nostuff_q, nostuff_d;
`ifdef RESYNC_EN
  logic           resync_done_q, resync_done_d;
`endif

  logic can_data_q, can_data_d;
  logic sample_q, sample_d;
  logic sof_q, sof_d;
  logic stuff_err_q, stuff_err_d;
  logic bus_idle_q, bus_idle_d;
  logic frame_active_q, frame_active_d;

  logic           fall_s, tq_tick_s, bit_tick_s, bit_s;
  logic           emit_s, sof_s, serr_s, go_idle_s, wrap_s;
  logic [TQW-1:0] tq_sum_s, jump_late_s, jump_early_s;

  assign fall_s     = rx_prev_q & ~rx_s_q;
  assign tq_tick_s  = (presc_q == PW'(CLK_PER_TQ - 1));
  assign bit_tick_s = tq_tick_s && (tq_q == TQW'(SAMPLE_TQ));
  assign bit_s      = rx_s_q;

  // State and output registers; the block assumes an idle (recessive) bus out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_prev_q      <= 1'b1;
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      tq_q           <= '0;
      run_q          <= 3'd0;
      last_q         <= 1'b1;
      idle_cnt_q     <= '0;
      nostuff_q      <= 1'b0;
`ifdef RESYNC_EN
      resync_done_q  <= 1'b0;
`endif
      can_data_q     <= 1'b1;
      sample_q       <= 1'b0;
      sof_q          <= 1'b0;
      stuff_err_q    <= 1'b0;
      bus_idle_q     <= 1'b1;
      frame_active_q <= 1'b0;
    end else begin
      rx_meta_q      <= can_rx;
      rx_s_q         <= rx_meta_q;
      rx_prev_q      <= rx_s_q;
      state_q        <= state_d;
      presc_q        <= presc_d;
      tq_q           <= tq_d;
      run_q          <= run_d;
      last_q         <= last_d;
      idle_cnt_q     <= idle_cnt_d;
      nostuff_q      <= nostuff_d;
`ifdef RESYNC_EN
      resync_done_q  <= resync_done_d;
`endif
      can_data_q     <= can_data_d;
      sample_q       <= sample_d;
      sof_q          <= sof_d;
      stuff_err_q    <= stuff_err_d;
      bus_idle_q     <= bus_idle_d;
      frame_active_q <= frame_active_d;
    end
  end

  // Next-state: bit timing, hard/soft sync, destuffing and idle tracking
  always_comb begin
    presc_d      = tq_tick_s ? '0 : presc_q + PW'(1);
    jump_late_s  = '0;
    jump_early_s = '0;
`ifdef RESYNC_EN
    resync_done_d = resync_done_q;
    if ((state_q != ST_IDLE) && fall_s && !resync_done_q && (tq_q != '0)) begin
      resync_done_d = 1'b1;
      // An edge in the last clk of the sample tq is already past the sample point
      if ((tq_q < TQW'(SAMPLE_TQ)) || ((tq_q == TQW'(SAMPLE_TQ)) && !tq_tick_s)) begin
        jump_late_s = (tq_q < TQW'(SJW)) ? tq_q : TQW'(SJW);
      end else begin
        jump_early_s = ((TQW'(TQ_PER_BIT) - tq_q) < TQW'(SJW)) ?
                       (TQW'(TQ_PER_BIT) - tq_q) : TQW'(SJW);
      end
    end else begin
      resync_done_d = resync_done_q;
    end
`endif
    tq_sum_s = tq_q + TQW'(tq_tick_s) + jump_early_s - jump_late_s;
    wrap_s   = (tq_sum_s >= TQW'(TQ_PER_BIT));
    tq_d     = wrap_s ? (tq_sum_s - TQW'(TQ_PER_BIT)) : tq_sum_s;
`ifdef RESYNC_EN
    if (wrap_s) begin
      resync_done_d = 1'b0;
    end else begin
      resync_done_d = resync_done_d;
    end
`endif

    state_d    = state_q;
    run_d      = run_q;
    last_d     = last_q;
    idle_cnt_d = idle_cnt_q;
    nostuff_d  = nostuff_q | destuff_stop;
    emit_s     = 1'b0;
    sof_s      = 1'b0;
    serr_s     = 1'b0;
    go_idle_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        nostuff_d = 1'b0;
        if (fall_s) begin
          presc_d    = '0;
          tq_d       = '0;
          state_d    = ST_ACTIVE;
          run_d      = 3'd0;
          idle_cnt_d = '0;
`ifdef RESYNC_EN
          resync_done_d = 1'b1;
`endif
        end else begin
          run_d = 3'd0;
        end
      end
      ST_ACTIVE, ST_ERROR: begin
        if (bit_tick_s) begin
          idle_cnt_d = bit_s ? (idle_cnt_q + IW'(1)) : '0;
          if (bit_s && (idle_cnt_q == IW'(IDLE_BITS - 1))) begin
            go_idle_s  = 1'b1;
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
          end else if (state_q == ST_ERROR) begin
            state_d = ST_ERROR;
          end else if (run_q == 3'd0) begin
            // SOF sample point: a recessive value means the falling edge was a glitch
            if (!bit_s) begin
              emit_s = 1'b1;
              sof_s  = 1'b1;
              run_d  = 3'd1;
              last_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (nostuff_q) begin
            emit_s = 1'b1;
            last_d = bit_s;
          end else if (run_q == 3'd5) begin
            if (bit_s != last_q) begin
              run_d  = 3'd1;
              last_d = bit_s;
            end else begin
              serr_s  = 1'b1;
              state_d = ST_ERROR;
            end
          end else begin
            emit_s = 1'b1;
            run_d  = (bit_s == last_q) ? (run_q + 3'd1) : 3'd1;
            last_d = bit_s;
          end
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode into the registered strobes and levels
  always_comb begin
    sample_d    = emit_s;
    sof_d       = sof_s;
    stuff_err_d = serr_s;
    if (emit_s) begin
      can_data_d = bit_s;
    end else begin
      can_data_d = can_data_q;
    end
    if (go_idle_s) begin
      bus_idle_d     = 1'b1;
      frame_active_d = 1'b0;
    end else if (sof_s) begin
      bus_idle_d     = 1'b0;
      frame_active_d = 1'b1;
    end else begin
      bus_idle_d     = bus_idle_q;
      frame_active_d = frame_active_q;
    end
  end

  assign can_data     = can_data_q;
  assign sample       = sample_q;
  assign sof          = sof_q;
  assign stuff_err    = stuff_err_q;
  assign bus_idle     = bus_idle_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_can_bit_sampler.sv
// Directed bench for can_bit_sampler: ideal-timing frames, destuffing, stuff error,
// destuff_stop, bus-idle detection, accumulated phase drift and mid-frame reset.
module tb_can_bit_sampler;

  logic clk = 1'b0;
  logic rst_n, can_rx, destuff_stop;
  logic can_data, sample, sof, stuff_err, bus_idle, frame_active;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   fall_cyc, sof_cyc, sof_idx, sof_cnt, serr_cnt;
  logic q_data[$];

  can_bit_sampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .can_rx       (can_rx),
    .destuff_stop (destuff_stop),
    .can_data     (can_data),
    .sample       (sample),
    .sof          (sof),
    .stuff_err    (stuff_err),
    .bus_idle     (bus_idle),
    .frame_active (frame_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect emitted bits and strobes away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sof === 1'b1) begin
        sof_cnt = sof_cnt + 1;
        sof_idx = q_data.size();
        sof_cyc = cyc;
      end
      if (stuff_err === 1'b1) serr_cnt = serr_cnt + 1;
      if (sample === 1'b1) q_data.push_back(can_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    q_data.delete();
    sof_cnt  = 0;
    serr_cnt = 0;
    sof_idx  = -1;
    sof_cyc  = 0;
  endtask

  task automatic send_bit(input logic b, input int len, input logic stop);
    can_rx = b;
    for (int i = 0; i < len; i++) begin
      destuff_stop = stop && (i == len - 2);
      @(posedge clk);
      #1;
    end
    destuff_stop = 1'b0;
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n, input int len);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], len, 1'b0);
  endtask

  task automatic check_data(input string tag, input logic [31:0] exp, input int n);
    logic v;
    check_val({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < n; i++) begin
      v = (i < q_data.size()) ? q_data[i] : 1'bx;
      check_val($sformatf("%s_bit%0d", tag, i), v, exp[n-1-i]);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    can_rx       = 1'b1;
    destuff_stop = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_can_data", can_data, 1);
    check_val("rst_sample", sample, 0);
    check_val("rst_sof", sof, 0);
    check_val("rst_stuff_err", stuff_err, 0);
    check_val("rst_bus_idle", bus_idle, 1);
    check_val("rst_frame_active", frame_active, 0);
    rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check_val("idle_samples", q_data.size(), 0);
    check_val("idle_bus_idle", bus_idle, 1);

    // SOF + 11'h552, no stuffing needed
    clear_mon();
    fall_cyc = cyc;
    send_seq(32'b0101_0101_0010, 12, 40);
    check_data("f552", 32'b0101_0101_0010, 12);
    check_val("f552_sof_cnt", sof_cnt, 1);
    check_val("f552_sof_idx", sof_idx, 0);
    check_val("f552_sof_latency", sof_cyc - fall_cyc, 35);
    check_val("f552_stuff_err", serr_cnt, 0);
    check_val("f552_frame_active", frame_active, 1);
    check_val("f552_bus_idle", bus_idle, 0);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 40, 1'b0);
    check_val("f552_idle_after10", bus_idle, 0);
    check_val("f552_tail_stuff_err", serr_cnt, 1);
    send_bit(1'b1, 40, 1'b0);
    check_val("f552_idle_after11", bus_idle, 1);
    check_val("f552_active_after11", frame_active, 0);

    // five dominant incl. SOF, stuff bit, then dominant
    clear_mon();
    send_seq(32'b0000010, 7, 40);
    check_data("stuff", 32'b000000, 6);
    check_val("stuff_err_none", serr_cnt, 0);
    for (int i = 0; i < 11; i++) send_bit(1'b1, 40, 1'b0);
    check_val("stuff_bus_idle", bus_idle, 1);

    // six dominant bits -> stuff error, then idle recovery
    clear_mon();
    send_seq(32'b000000, 6, 40);
    check_data("six", 32'b00000, 5);
    check_val("six_stuff_err", serr_cnt, 1);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 40, 1'b0);
    check_val("six_idle_after10", bus_idle, 0);
    send_bit(1'b1, 40, 1'b0);
    check_val("six_idle_after11", bus_idle, 1);
    check_val("six_no_more_samples", q_data.size(), 5);

    // destuff_stop, then 10 recessive bits emitted, 11th declares idle
    clear_mon();
    send_bit(1'b0, 40, 1'b0);
    send_bit(1'b1, 40, 1'b0);
    send_bit(1'b0, 40, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 40, 1'b0);
    check_data("dstop", 32'b0100_0000_0000_0 | 32'b0_0011_1111_1111, 13);
    check_val("dstop_stuff_err", serr_cnt, 0);
    check_val("dstop_idle_after10", bus_idle, 0);
    send_bit(1'b1, 40, 1'b0);
    check_val("dstop_idle_after11", bus_idle, 1);
    check_val("dstop_final_count", q_data.size(), 13);

`ifndef RESYNC_EN
    // 50-clk bits with a free-running tq counter: bit 5 lands in bit 4's window
    clear_mon();
    send_seq(32'b01010, 5, 50);
    check_data("drift", 32'b010110, 6);
    for (int i = 0; i < 13; i++) send_bit(1'b1, 40, 1'b0);
    check_val("drift_bus_idle", bus_idle, 1);
`endif

    // reset in the middle of a frame
    clear_mon();
    send_seq(32'b010, 3, 40);
    can_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("mid_frame_active", frame_active, 1);
    check_val("mid_can_data", can_data, 0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_bus_idle", bus_idle, 1);
    check_val("mid_rst_frame_active", frame_active, 0);
    check_val("mid_rst_can_data", can_data, 1);
    check_val("mid_rst_sample", sample, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (500) @(posedge clk);
    #1;
    check_val("post_rst_samples", q_data.size(), 0);
    check_val("post_rst_bus_idle", bus_idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/can_bit_sampler.md
Name: can_bit_sampler

Overview:
Upstream stage of the CAN frame decoder. Takes the raw, asynchronous CAN RX line and produces the decoder's `can_data` / `sample` bit stream.
- Bit timing: prescaled time quanta, hard sync on start of frame, sample-point capture.
- Bit destuffing, stuff-error detection, bus-idle detection.
- Each emitted `sample` pulse carries one destuffed frame bit, starting with the SOF bit.

Parameters:
- CLK_PER_TQ, 4: clk cycles per time quantum (>=2).
- TQ_PER_BIT, 10: time quanta per nominal bit (8..25); tq 0 is the sync segment.
- SAMPLE_TQ, 7: tq index at which the bus is sampled (2..TQ_PER_BIT-2).
- SJW, 2: resync jump width in tq (used only with RESYNC_EN).
- IDLE_BITS, 11: consecutive recessive bits that declare bus idle.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- can_rx, input, 1: raw CAN line, asynchronous; 1 = recessive.
- destuff_stop, input, 1: one-clk pulse from the decoder after the CRC field; disables destuffing for the rest of the frame.
- can_data, output, 1: destuffed bit value; valid when sample=1 and held until the next pulse.
- sample, output, 1: one-clk strobe per destuffed bit.
- sof, output, 1: one-clk pulse coincident with the sample of the SOF bit.
- stuff_err, output, 1: one-clk pulse when six equal bits are seen while destuffing.
- bus_idle, output, 1: level; 1 after IDLE_BITS recessive bits.
- frame_active, output, 1: level; 1 from SOF until bus_idle.

Behaviour:
- Reset (async, rst_n=0), all outputs:
  - can_data=1, sample=0, sof=0, stuff_err=0, frame_active=0.
  - bus_idle=1; the block assumes an idle bus out of reset.
  - Synchronizer flops = 1; counters = 0; state = IDLE.
- Input path and counters:
  - can_rx passes through a 2-flop synchronizer (rx_s).
  - Prescaler counts 0..CLK_PER_TQ-1 and emits tq_tick on wrap.
  - tq counter counts 0..TQ_PER_BIT-1 on tq_tick.
  - The bit value is rx_s captured on the tq_tick that ends tq SAMPLE_TQ.
- States: IDLE, ACTIVE, ERROR.
- IDLE:
  - A 1->0 transition on rx_s is a hard sync: prescaler and tq counter reset to 0 on the same clk.
  - Then go to ACTIVE and clear the run counter.
  - Output latency: the SOF bit's sample/sof pulse occurs the clk after its sample point, i.e. (SAMPLE_TQ+1)*CLK_PER_TQ+1 clks after the rx_s edge.
  - Defaults (+2 synchronizer clks): 33 clks after the rx_s edge, 35 clks after the can_rx edge.
- ACTIVE, per sampled bit with destuffing enabled:
  - Track run length of equal bits (1..5) and the last bit value.
  - Bit after a run of 5, with opposite value: stuff bit. It is dropped (no sample pulse) and the run restarts at 1 with the new value.
  - Bit after a run of 5, with equal value: stuff_err pulses, no sample pulse, go to ERROR.
  - Otherwise: sample pulses with can_data = bit.
  - Stuff bits count toward the next run.
- destuff_stop:
  - From then on every sampled bit is emitted; no stuff checks.
  - If it arrives on the same clk as a stuff-bit decision, that decision completes first.
- Idle counter:
  - Counts consecutive recessive sampled bits in ACTIVE and ERROR, including stuff bits.
  - Any dominant bit clears it.
  - Reaching IDLE_BITS: bus_idle=1, frame_active=0, state = IDLE. No sample pulse for that final bit.
  - A dominant bit in ERROR keeps the state ERROR and restarts the count.
- ERROR: no sample pulses; exits only via the idle counter.
- Mid-operation reset: returns immediately to reset values; a frame in progress is abandoned.
- sample, sof, stuff_err: never asserted for more than one clk; at most one sample per bit time.

Optional Feature:
- Macro: RESYNC_EN.
- Defined: in ACTIVE/ERROR, a 1->0 rx_s edge at tq index e (e != 0) triggers a soft resync; at most one resync per bit, none in the bit the edge is sampled in after a hard sync.
  - 0 < e <= SAMPLE_TQ (late edge): phase seg1 is lengthened by min(e, SJW) tq.
  - e > SAMPLE_TQ (early edge): the current bit is shortened by min(TQ_PER_BIT-e, SJW) tq.
- Undefined: only the hard sync at SOF; the tq counter free-runs through the frame.

Test Plan:
- Reset release with can_rx=1 -> bus_idle=1, sample=0 for 1000 clks.
- Bits 0, 11'h552 stuffed (sequence 0 10101 010010), ideal 40-clk bits -> 12 sample pulses; can_data sequence = the 12 bits; sof on the first pulse, 35 clks after the can_rx fall.
- Stuffed stream 0 00001 0 (five 0s incl. SOF, stuff 1, then 0) -> 6 sample pulses, stuff bit dropped, stuff_err=0.
- Six consecutive dominant bits -> 5 pulses then stuff_err pulse, state ERROR; 11 recessive bits -> bus_idle=1.
- destuff_stop, then 7 recessive EOF bits + 3 intermission bits -> 10 pulses, no stuff_err; 11th recessive bit sets bus_idle.
- RESYNC_EN: bit edges 2 tq late each bit -> all bits sampled correctly; without RESYNC_EN over 5 bits, bit 5 is mis-sampled.
